// File: rtl/apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// apb_master_arbiter
//   Two-requester APB master. Round-robin arbitration between two local
//   request ports. Sequences the shared APB bus through IDLE/SETUP/ACCESS.
//   Returns exactly one response per accepted request, on the port that
//   issued it. Addresses above UPPER_ADDR_LIMIT are rejected locally and
//   never reach the bus.
//
//   Optional feature (macro APB_TIMEOUT_EN):
//     Adds an ACCESS-phase wait counter and the TIMEOUT_CYCLES parameter.
//     The transfer aborts with err=1 if pready stays low for TIMEOUT_CYCLES
//     consecutive ACCESS cycles. Without the macro, ACCESS waits for pready
//     indefinitely.
//
// Ports
//   pclk, presetn                clock, async active-low reset
//   reqN_valid/write/addr/wdata  requester N transfer request
//   reqN_ready                   combinational accept for requester N
//   rspN_valid/rdata/err         one-cycle registered response pulse
//   psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr  APB bus
// ---------------------------------------------------------------------------
module apb_master_arbiter #(
   parameter int unsigned DATA_WIDTH       = 8,
   parameter int unsigned ADDR_WIDTH       = 8,
   parameter int unsigned UPPER_ADDR_LIMIT = 200
`ifdef APB_TIMEOUT_EN
   , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  req0_valid,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   output logic                  req0_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp0_err,
   input  logic                  req1_valid,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   output logic                  req1_ready,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  rsp1_err,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pready,
   input  logic                  pslverr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

`ifdef APB_TIMEOUT_EN
   localparam int unsigned CNT_MIN_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned WAIT_CNT_W = (CNT_MIN_W > 5) ? CNT_MIN_W : 5;
`endif

   state_e                state_q;
   logic                  last_grant_q;   // 1 = requester 1 won last
   logic                  owner_q;        // requester owning the bus transfer
   logic                  psel_q;
   logic                  penable_q;
   logic                  pwrite_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [DATA_WIDTH-1:0] pwdata_q;
   logic                  rsp0_valid_q;
   logic [DATA_WIDTH-1:0] rsp0_rdata_q;
   logic                  rsp0_err_q;
   logic                  rsp1_valid_q;
   logic [DATA_WIDTH-1:0] rsp1_rdata_q;
   logic                  rsp1_err_q;
`ifdef APB_TIMEOUT_EN
   logic [WAIT_CNT_W-1:0] wait_cnt_q;
   logic                  timeout_c;
`endif

   logic                  grant0_c;
   logic                  grant1_c;
   logic                  accept_c;
   logic                  sel_write_c;
   logic [ADDR_WIDTH-1:0] sel_addr_c;
   logic [DATA_WIDTH-1:0] sel_wdata_c;
   logic                  sel_legal_c;
   logic                  rsp_fire_c;
   logic                  rsp_port_c;
   logic                  rsp_err_c;
   logic [DATA_WIDTH-1:0] rsp_rdata_c;

`ifdef APB_TIMEOUT_EN
   // Last permitted wait cycle: pready still low here means abort
   assign timeout_c = (wait_cnt_q == WAIT_CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // Round-robin grant, evaluated only while the bus is idle
   always_comb begin
      grant0_c = 1'b0;
      grant1_c = 1'b0;
      if (state_q == IDLE) begin
         if (req0_valid && req1_valid) begin
            grant0_c = last_grant_q;
            grant1_c = !last_grant_q;
         end else if (req0_valid) begin
            grant0_c = 1'b1;
         end else if (req1_valid) begin
            grant1_c = 1'b1;
         end
      end
   end

   assign accept_c    = grant0_c || grant1_c;
   assign sel_write_c = grant1_c ? req1_write : req0_write;
   assign sel_addr_c  = grant1_c ? req1_addr  : req0_addr;
   assign sel_wdata_c = grant1_c ? req1_wdata : req0_wdata;
   assign sel_legal_c = (sel_addr_c <= ADDR_WIDTH'(UPPER_ADDR_LIMIT));

   // Response source: local rejection, bus completion or timeout abort
   always_comb begin
      rsp_fire_c  = 1'b0;
      rsp_port_c  = owner_q;
      rsp_err_c   = 1'b0;
      rsp_rdata_c = '0;
      case (state_q)
         IDLE: begin
            if (accept_c && !sel_legal_c) begin
               rsp_fire_c = 1'b1;
               rsp_port_c = grant1_c;
               rsp_err_c  = 1'b1;
            end
         end
         ACCESS: begin
            if (pready) begin
               rsp_fire_c  = 1'b1;
               rsp_err_c   = pslverr;
               rsp_rdata_c = (!pwrite_q && !pslverr) ? prdata : '0;
`ifdef APB_TIMEOUT_EN
            end else if (timeout_c) begin
               rsp_fire_c = 1'b1;
               rsp_err_c  = 1'b1;
`endif
            end
         end
         default: ;
      endcase
   end

   // Bus sequencer, arbitration state and response registers
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         rsp0_valid_q <= 1'b0;
         rsp0_rdata_q <= '0;
         rsp0_err_q   <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp1_rdata_q <= '0;
         rsp1_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wait_cnt_q   <= '0;
`endif
      end else begin
         rsp0_valid_q <= rsp_fire_c && !rsp_port_c;
         rsp0_err_q   <= rsp_fire_c && !rsp_port_c && rsp_err_c;
         rsp0_rdata_q <= (rsp_fire_c && !rsp_port_c) ? rsp_rdata_c : '0;
         rsp1_valid_q <= rsp_fire_c && rsp_port_c;
         rsp1_err_q   <= rsp_fire_c && rsp_port_c && rsp_err_c;
         rsp1_rdata_q <= (rsp_fire_c && rsp_port_c) ? rsp_rdata_c : '0;

         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  last_grant_q <= grant1_c;
                  owner_q      <= grant1_c;
                  // Rejected addresses leave the bus untouched
                  if (sel_legal_c) begin
                     state_q   <= SETUP;
                     psel_q    <= 1'b1;
                     penable_q <= 1'b0;
                     pwrite_q  <= sel_write_c;
                     paddr_q   <= sel_addr_c;
                     pwdata_q  <= sel_write_c ? sel_wdata_c : '0;
                  end
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end
            ACCESS: begin
               if (pready) begin
                  state_q   <= IDLE;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
               end else if (timeout_c) begin
                  state_q   <= IDLE;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WAIT_CNT_W'(1);
`endif
               end
            end
            default: begin
               state_q   <= IDLE;
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

   assign req0_ready = grant0_c;
   assign req1_ready = grant1_c;
   assign psel       = psel_q;
   assign penable    = penable_q;
   assign pwrite     = pwrite_q;
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp0_rdata = rsp0_rdata_q;
   assign rsp0_err   = rsp0_err_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp1_rdata = rsp1_rdata_q;
   assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arbiter
//   Directed bench for apb_master_arbiter. Stimulus pushes requests into
//   per-port driver queues and the expected responses into per-port
//   scoreboard queues; a monitor pops and compares on every rsp pulse.
//   A small APB slave model inserts a configurable number of wait states.
// ---------------------------------------------------------------------------
module tb_apb_master_arbiter;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
   } req_t;

   typedef struct {
      logic       err;
      logic [7:0] rdata;
   } exp_t;

   logic       pclk = 1'b0;
   logic       presetn = 1'b0;
   logic       req0_valid = 1'b0, req0_write = 1'b0;
   logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
   logic       req1_valid = 1'b0, req1_write = 1'b0;
   logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
   logic       req0_ready, req1_ready;
   logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [7:0] rsp0_rdata, rsp1_rdata;
   logic       psel, penable, pwrite;
   logic [7:0] paddr, pwdata;
   logic [7:0] prdata = 8'h00;
   logic       pready = 1'b0, pslverr = 1'b0;

   int         compares = 0;
   int         mismatches = 0;
   int         cyc = 0;
   int         acc_cnt0 = 0, acc_cnt1 = 0;
   int         acc_port[$];
   int         acc_cyc[$];
   req_t       rq0[$], rq1[$];
   exp_t       eq0[$], eq1[$];

   // Slave model configuration
   int         cfg_wait = 0;
   logic       cfg_slverr = 1'b0;
   logic [7:0] cfg_rdata = 8'h00;
   int         acc_n = 0;

   apb_master_arbiter dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .req0_valid (req0_valid),
      .req0_write (req0_write),
      .req0_addr  (req0_addr),
      .req0_wdata (req0_wdata),
      .req0_ready (req0_ready),
      .rsp0_valid (rsp0_valid),
      .rsp0_rdata (rsp0_rdata),
      .rsp0_err   (rsp0_err),
      .req1_valid (req1_valid),
      .req1_write (req1_write),
      .req1_addr  (req1_addr),
      .req1_wdata (req1_wdata),
      .req1_ready (req1_ready),
      .rsp1_valid (rsp1_valid),
      .rsp1_rdata (rsp1_rdata),
      .rsp1_err   (rsp1_err),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr)
   );

   always #5 pclk = ~pclk;

   always @(posedge pclk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      compares++;
      if (act !== req) begin
         mismatches++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // APB slave: pready after cfg_wait ACCESS cycles
   always @(negedge pclk) begin
      if (psel && penable) begin
         if (acc_n >= cfg_wait) begin
            pready  = 1'b1;
            pslverr = cfg_slverr;
            prdata  = cfg_rdata;
         end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
            prdata  = 8'h00;
         end
         acc_n++;
      end else begin
         acc_n   = 0;
         pready  = 1'b0;
         pslverr = 1'b0;
         prdata  = 8'h00;
      end
   end

   // Monitor: log accepts, score responses
   always @(negedge pclk) begin
      exp_t e;
      if (presetn) begin
         if (req0_valid && req0_ready) begin
            acc_cnt0++;
            acc_port.push_back(0);
            acc_cyc.push_back(cyc);
         end
         if (req1_valid && req1_ready) begin
            acc_cnt1++;
            acc_port.push_back(1);
            acc_cyc.push_back(cyc);
         end
         if (rsp0_valid) begin
            if (eq0.size() == 0) begin
               chk("rsp0_unexpected", 32'd1, 32'd0);
            end else begin
               e = eq0.pop_front();
               chk("rsp0_err", 32'(rsp0_err), 32'(e.err));
               chk("rsp0_rdata", 32'(rsp0_rdata), 32'(e.rdata));
            end
         end
         if (rsp1_valid) begin
            if (eq1.size() == 0) begin
               chk("rsp1_unexpected", 32'd1, 32'd0);
            end else begin
               e = eq1.pop_front();
               chk("rsp1_err", 32'(rsp1_err), 32'(e.err));
               chk("rsp1_rdata", 32'(rsp1_rdata), 32'(e.rdata));
            end
         end
      end
   end

   // Requester 0 driver: holds a request until accepted
   initial begin : drv0
      int   seen;
      req_t r;
      seen = 0;
      forever begin
         @(posedge pclk);
         #1;
         if (acc_cnt0 != seen) begin
            seen       = acc_cnt0;
            req0_valid = 1'b0;
         end
         if (!req0_valid && rq0.size() > 0) begin
            r          = rq0.pop_front();
            req0_write = r.wr;
            req0_addr  = r.addr;
            req0_wdata = r.wdata;
            req0_valid = 1'b1;
         end
      end
   end

   // Requester 1 driver
   initial begin : drv1
      int   seen;
      req_t r;
      seen = 0;
      forever begin
         @(posedge pclk);
         #1;
         if (acc_cnt1 != seen) begin
            seen       = acc_cnt1;
            req1_valid = 1'b0;
         end
         if (!req1_valid && rq1.size() > 0) begin
            r          = rq1.pop_front();
            req1_write = r.wr;
            req1_addr  = r.addr;
            req1_wdata = r.wdata;
            req1_valid = 1'b1;
         end
      end
   end

   task automatic issue(input int port, input logic wr, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic has_rsp,
                        input logic e_err, input logic [7:0] e_rdata);
      req_t r;
      exp_t e;
      r.wr = wr; r.addr = addr; r.wdata = wdata;
      e.err = e_err; e.rdata = e_rdata;
      if (port == 0) begin
         rq0.push_back(r);
         if (has_rsp) eq0.push_back(e);
      end else begin
         rq1.push_back(r);
         if (has_rsp) eq1.push_back(e);
      end
   endtask

   task automatic wait_accept(input int port, input string name);
      int n;
      n = 0;
      forever begin
         @(negedge pclk);
         if (port == 0 && req0_valid && req0_ready) break;
         if (port == 1 && req1_valid && req1_ready) break;
         n++;
         if (n > 50) begin
            chk({name, "_accept_timeout"}, 32'd1, 32'd0);
            break;
         end
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (rq0.size() != 0 || rq1.size() != 0 || eq0.size() != 0 ||
             eq1.size() != 0 || req0_valid || req1_valid) begin
         @(negedge pclk);
         n++;
         if (n > 300) begin
            chk({name, "_drain_timeout"}, 32'd1, 32'd0);
            eq0.delete();
            eq1.delete();
            break;
         end
      end
      repeat (3) @(negedge pclk);
   endtask

   // Hard stop if a step ever loses its bound
   initial begin
      #400000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n;
      // Reset values
      presetn = 1'b0;
      repeat (3) @(negedge pclk);
      chk("reset_psel", 32'(psel), 32'd0);
      chk("reset_penable", 32'(penable), 32'd0);
      chk("reset_paddr", 32'(paddr), 32'd0);
      chk("reset_pwdata", 32'(pwdata), 32'd0);
      chk("reset_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
      presetn = 1'b1;
      @(negedge pclk);

      // Write, no wait states
      cfg_wait = 0;
      issue(0, 1'b1, 8'h33, 8'h88, 1'b1, 1'b0, 8'h00);
      wait_accept(0, "wr");
      @(negedge pclk);
      chk("wr_t1_psel", 32'(psel), 32'd1);
      chk("wr_t1_penable", 32'(penable), 32'd0);
      chk("wr_t1_pwrite", 32'(pwrite), 32'd1);
      chk("wr_t1_paddr", 32'(paddr), 32'h33);
      chk("wr_t1_pwdata", 32'(pwdata), 32'h88);
      @(negedge pclk);
      chk("wr_t2_psel", 32'(psel), 32'd1);
      chk("wr_t2_penable", 32'(penable), 32'd1);
      @(negedge pclk);
      chk("wr_t3_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("wr_t3_psel", 32'(psel), 32'd0);
      chk("wr_t3_paddr_hold", 32'(paddr), 32'h33);
      drain("wr");

      // Read with two wait states
      cfg_wait  = 2;
      cfg_rdata = 8'h5A;
      issue(1, 1'b0, 8'h01, 8'hEE, 1'b1, 1'b0, 8'h5A);
      wait_accept(1, "rd");
      @(negedge pclk);
      chk("rd_t1_psel_pen", 32'({psel, penable}), 32'b10);
      chk("rd_t1_pwrite", 32'(pwrite), 32'd0);
      chk("rd_t1_pwdata", 32'(pwdata), 32'h00);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge pclk);
         if (!(psel && penable)) break;
         n++;
         chk("rd_access_paddr", 32'(paddr), 32'h01);
      end
      chk("rd_access_cycles", 32'(n), 32'd3);
      chk("rd_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("rd_rsp0_quiet", 32'(rsp0_valid), 32'd0);
      drain("rd");

      // Illegal address: no bus cycle, immediate error response
      cfg_wait = 0;
      issue(0, 1'b1, 8'hC9, 8'h11, 1'b1, 1'b1, 8'h00);
      wait_accept(0, "ill");
      @(negedge pclk);
      chk("ill_psel", 32'(psel), 32'd0);
      chk("ill_paddr_untouched", 32'(paddr), 32'h01);
      chk("ill_rsp0_valid", 32'(rsp0_valid), 32'd1);
      drain("ill");

      // Highest legal address goes to the bus
      issue(1, 1'b1, 8'hC8, 8'h42, 1'b1, 1'b0, 8'h00);
      wait_accept(1, "lim");
      @(negedge pclk);
      chk("lim_psel", 32'(psel), 32'd1);
      chk("lim_paddr", 32'(paddr), 32'hC8);
      drain("lim");

      // Slave error on a read: err=1, rdata forced to 0
      cfg_slverr = 1'b1;
      cfg_rdata  = 8'h77;
      issue(0, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 8'h00);
      drain("slverr");
      cfg_slverr = 1'b0;

      // Round-robin with both requesters continuously valid after reset
      presetn = 1'b0;
      @(negedge pclk);
      presetn = 1'b1;
      acc_port.delete();
      acc_cyc.delete();
      cfg_rdata = 8'h3C;
      issue(0, 1'b1, 8'h40, 8'hA1, 1'b1, 1'b0, 8'h00);
      issue(0, 1'b1, 8'h41, 8'hA2, 1'b1, 1'b0, 8'h00);
      issue(1, 1'b0, 8'h50, 8'h00, 1'b1, 1'b0, 8'h3C);
      issue(1, 1'b0, 8'h51, 8'h00, 1'b1, 1'b0, 8'h3C);
      drain("rr");
      chk("rr_accept_count", 32'(acc_port.size()), 32'd4);
      if (acc_port.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("rr_grant_order", 32'(acc_port[i]), 32'(i % 2));
            if (i > 0) chk("rr_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
         end
      end

      // Reset asserted during ACCESS: everything clears, no response
      cfg_wait = 50;
      issue(1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b0, 8'h00);
      n = 0;
      while (!(psel && penable) && n < 50) begin
         @(negedge pclk);
         n++;
      end
      chk("rst_reached_access", 32'(psel && penable), 32'd1);
      #2;
      presetn = 1'b0;
      #1;
      chk("rst_async_psel_pen", 32'({psel, penable}), 32'd0);
      chk("rst_async_pwrite", 32'(pwrite), 32'd0);
      chk("rst_async_paddr", 32'(paddr), 32'd0);
      chk("rst_async_pwdata", 32'(pwdata), 32'd0);
      chk("rst_async_rsp", 32'({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}), 32'd0);
      repeat (2) @(negedge pclk);
      cfg_wait = 0;
      presetn  = 1'b1;
      acc_port.delete();
      acc_cyc.delete();
      cfg_rdata = 8'h99;
      issue(0, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 8'h99);
      issue(1, 1'b0, 8'h06, 8'h00, 1'b1, 1'b0, 8'h99);
      drain("rst");
      chk("rst_first_tie_port0", 32'((acc_port.size() > 0) ? acc_port[0] : 9), 32'd0);

`ifdef APB_TIMEOUT_EN
      // pready never arrives: abort after 16 ACCESS cycles
      cfg_wait = 1000;
      issue(0, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h00);
      wait_accept(0, "to");
      @(negedge pclk);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge pclk);
         if (!(psel && penable)) break;
         n++;
      end
      chk("to_access_cycles", 32'(n), 32'd16);
      chk("to_psel", 32'(psel), 32'd0);
      chk("to_rsp0_valid", 32'(rsp0_valid), 32'd1);
      drain("to");
      cfg_wait = 0;
`endif

      chk("final_eq0_empty", 32'(eq0.size()), 32'd0);
      chk("final_eq1_empty", 32'(eq1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
      $finish;
   end

endmodule
